// File: rtl/dm_serial.sv
// dm_serial: byte-serial data memory for the 24-bit RISC datapath.
//
// Storage is a single-port byte array. Each accepted request is moved one
// byte per clock, most significant byte first (big-endian): the byte at
// req_addr_i is the top byte of the N accessed bytes. Loads may be
// sign-extended. Bad requests are answered with rsp_err_o and do not touch
// storage.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid_i       request present
//   req_ready_o       block can accept a request (high only in IDLE)
//   req_we_i          1 = store, 0 = load
//   req_size_i        0 = 1 byte, 1 = 2 bytes, 2 = WORD_BYTES bytes, 3 = error
//   req_signed_i      sign-extend the load result
//   req_addr_i        byte address of the most significant accessed byte
//   req_wdata_i       store data, low N bytes used
//   rsp_valid_o       one-cycle completion strobe
//   rsp_rdata_o       load result (0 for stores and errors), held until next response
//   rsp_err_o         request rejected, held until next response
//
// Build option
//   DM_ALIGN_CHECK_EN  when defined, odd half-word addresses and word
//                      addresses not a multiple of WORD_BYTES are errors;
//                      when undefined any alignment is allowed and
//                      multi-byte accesses wrap at DEPTH.
module dm_serial #(
  parameter int WORD_BYTES = 3,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_signed_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [8*WORD_BYTES-1:0] req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [8*WORD_BYTES-1:0] rsp_rdata_o,
  output logic                    rsp_err_o
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic              ready_q;
  logic              rsp_valid_q;
  logic [DW-1:0]     rsp_rdata_q;
  logic              rsp_err_q;
  logic              we_q;
  logic              signed_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [CNT_W-1:0]  last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DW-1:0]     shift_q;
  logic [7:0]        mem_q [DEPTH];

  logic [CNT_W-1:0]  last_d;
  logic [DW-1:0]     shift_d;
  logic              size_err_s;
  logic              misalign_s;
  logic              req_err_s;
  logic [AW:0]       sum_s;
  logic [AW-1:0]     idx_s;
  logic [CNT_W-1:0]  lane_s;
  logic [7:0]        wbyte_s;
  logic [7:0]        rbyte_s;

  // Keep the low (last+1) bytes of v; fill the rest with zeros or the sign bit.
  function automatic logic [DW-1:0] extend_load(input logic [DW-1:0]    v,
                                                input logic [CNT_W-1:0] last,
                                                input logic             sgn);
    logic [DW-1:0] r;
    logic          fill;
    fill = sgn & v[int'(last) * 8 + 7];
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (b <= int'(last)) begin
        r[b*8 +: 8] = v[b*8 +: 8];
      end else begin
        r[b*8 +: 8] = {8{fill}};
      end
    end
    return r;
  endfunction

  // Decode the access size into the index of the last byte; size 3 is an error.
  always_comb begin
    last_d     = '0;
    size_err_s = 1'b0;
    case (req_size_i)
      2'd0:    last_d = CNT_W'(0);
      2'd1:    last_d = CNT_W'(1);
      2'd2:    last_d = CNT_W'(WORD_BYTES - 1);
      default: size_err_s = 1'b1;
    endcase
  end

  // Alignment check on the incoming request (compiled in only when enabled).
  always_comb begin
`ifdef DM_ALIGN_CHECK_EN
    if (req_size_i == 2'd1) begin
      misalign_s = req_addr_i[0];
    end else if (req_size_i == 2'd2) begin
      misalign_s = (req_addr_i % ADDR_W'(WORD_BYTES)) != '0;
    end else begin
      misalign_s = 1'b0;
    end
`else
    misalign_s = 1'b0;
`endif
  end

  // Combine all rejection reasons for the incoming request.
  always_comb begin
    req_err_s = size_err_s | misalign_s | (req_addr_i >= ADDR_W'(DEPTH));
  end

  // Current byte address (addr + cnt) mod DEPTH. addr_q < DEPTH and
  // cnt < WORD_BYTES, so at most one subtraction is needed; the wrapped
  // result always fits in AW bits.
  always_comb begin
    sum_s = {1'b0, addr_q} + (AW+1)'(cnt_q);
    if (sum_s >= (AW+1)'(DEPTH)) begin
      idx_s = sum_s[AW-1:0] - AW'(DEPTH);
    end else begin
      idx_s = sum_s[AW-1:0];
    end
  end

  // Byte lanes: stores send lane N-1-cnt first; loads shift each byte in at the bottom.
  always_comb begin
    lane_s  = last_q - cnt_q;
    wbyte_s = wdata_q[int'(lane_s) * 8 +: 8];
    rbyte_s = mem_q[idx_s];
    shift_d = {shift_q[DW-9:0], rbyte_s};
  end

  // Byte storage: one byte written per store XFER cycle, contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == XFER && we_q) begin
      mem_q[idx_s] <= wbyte_s;
    end
  end

  // Request/transfer/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (req_valid_i) begin
            we_q     <= req_we_i;
            signed_q <= req_signed_i;
            addr_q   <= req_addr_i[AW-1:0];
            wdata_q  <= req_wdata_i;
            last_q   <= last_d;
            cnt_q    <= '0;
            shift_q  <= '0;
            ready_q  <= 1'b0;
            if (req_err_s) begin
              // Rejected: skip storage entirely and answer next cycle.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!we_q) begin
            shift_q <= shift_d;
          end
          if (cnt_q == last_q) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : extend_load(shift_d, last_q, signed_q);
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dm_serial.sv
// Directed bench for dm_serial (WORD_BYTES = 3, DEPTH = 256, ADDR_W = 24).
module tb_dm_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [23:0] req_addr = 24'd0;
  logic [23:0] req_wdata = 24'd0;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

`ifdef DM_ALIGN_CHECK_EN
  localparam logic [23:0] WA = 24'd3;
`else
  localparam logic [23:0] WA = 24'd4;
`endif

  dm_serial #(.WORD_BYTES(3), .DEPTH(256), .ADDR_W(24)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for its response; lat counts
  // falling edges after the accepting rising edge (99 = no response).
  task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [23:0] addr, input logic [23:0] wdata,
                        output logic [23:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = 99; rdata = 24'h0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        lat = i; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end checks++;
    if (rsp_rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 000000", rsp_rdata); end checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rsp_err); end checks++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    logic [23:0] rd; logic er; int lt;
    logic [23:0] exp_b [3];
    exp_b[0] = 24'h0000A1; exp_b[1] = 24'h0000B2; exp_b[2] = 24'h0000C3;
    run_op(1'b1, 2'd2, 1'b0, WA, 24'hA1B2C3, rd, er, lt);
    if (lt !== 4) begin errors++; $display("FAIL word_store_lat: got %0d expected 4", lt); end checks++;
    if (er !== 1'b0 || rd !== 24'h0) begin errors++; $display("FAIL word_store_rsp: got err %b rdata %h expected 0 000000", er, rd); end checks++;
    run_op(1'b0, 2'd2, 1'b0, WA, 24'h0, rd, er, lt);
    if (lt !== 4) begin errors++; $display("FAIL word_load_lat: got %0d expected 4", lt); end checks++;
    if (rd !== 24'hA1B2C3) begin errors++; $display("FAIL word_load_data: got %h expected a1b2c3", rd); end checks++;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, 2'd0, 1'b0, WA + 24'(k), 24'h0, rd, er, lt);
      if (lt !== 2) begin errors++; $display("FAIL byte_load_lat[%0d]: got %0d expected 2", k, lt); end checks++;
      if (rd !== exp_b[k]) begin errors++; $display("FAIL byte_load_data[%0d]: got %h expected %h", k, rd, exp_b[k]); end checks++;
    end
  endtask

  task automatic test_sign;
    logic [23:0] rd; logic er; int lt;
    run_op(1'b1, 2'd0, 1'b0, 24'd9, 24'h000080, rd, er, lt);
    run_op(1'b0, 2'd0, 1'b1, 24'd9, 24'h0, rd, er, lt);
    if (rd !== 24'hFFFF80) begin errors++; $display("FAIL sbyte_signed: got %h expected ffff80", rd); end checks++;
    run_op(1'b0, 2'd0, 1'b0, 24'd9, 24'h0, rd, er, lt);
    if (rd !== 24'h000080) begin errors++; $display("FAIL sbyte_unsigned: got %h expected 000080", rd); end checks++;
    run_op(1'b1, 2'd1, 1'b0, 24'd10, 24'h007F10, rd, er, lt);
    if (lt !== 3) begin errors++; $display("FAIL half_store_lat: got %0d expected 3", lt); end checks++;
    run_op(1'b0, 2'd1, 1'b1, 24'd10, 24'h0, rd, er, lt);
    if (rd !== 24'h007F10) begin errors++; $display("FAIL half_pos_signed: got %h expected 007f10", rd); end checks++;
    run_op(1'b0, 2'd1, 1'b0, 24'd10, 24'h0, rd, er, lt);
    if (rd !== 24'h007F10) begin errors++; $display("FAIL half_pos_unsigned: got %h expected 007f10", rd); end checks++;
    run_op(1'b1, 2'd1, 1'b0, 24'd16, 24'h008001, rd, er, lt);
    run_op(1'b0, 2'd1, 1'b1, 24'd16, 24'h0, rd, er, lt);
    if (rd !== 24'hFF8001) begin errors++; $display("FAIL half_neg_signed: got %h expected ff8001", rd); end checks++;
    run_op(1'b0, 2'd1, 1'b0, 24'd16, 24'h0, rd, er, lt);
    if (rd !== 24'h008001) begin errors++; $display("FAIL half_neg_unsigned: got %h expected 008001", rd); end checks++;
  endtask

  task automatic test_range;
    logic [23:0] rd; logic er; int lt;
    run_op(1'b1, 2'd0, 1'b0, 24'd0, 24'h0000A5, rd, er, lt);
    run_op(1'b0, 2'd2, 1'b0, WA, 24'h0, rd, er, lt);
    run_op(1'b0, 2'd2, 1'b0, 24'd256, 24'h0, rd, er, lt);
    if (lt !== 1) begin errors++; $display("FAIL range_load_lat: got %0d expected 1", lt); end checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL range_load_err: got %b expected 1", er); end checks++;
    if (rd !== 24'h0) begin errors++; $display("FAIL range_load_rdata: got %h expected 000000", rd); end checks++;
    run_op(1'b1, 2'd0, 1'b0, 24'd256, 24'h000055, rd, er, lt);
    if (er !== 1'b1 || lt !== 1) begin errors++; $display("FAIL range_store: got err %b lat %0d expected 1 1", er, lt); end checks++;
    run_op(1'b0, 2'd0, 1'b0, 24'd0, 24'h0, rd, er, lt);
    if (rd !== 24'h0000A5 || er !== 1'b0) begin errors++; $display("FAIL range_store_untouched: got %h err %b expected 0000a5 0", rd, er); end checks++;
    run_op(1'b0, 2'd0, 1'b0, 24'h800000, 24'h0, rd, er, lt);
    if (er !== 1'b1) begin errors++; $display("FAIL range_high_addr: got err %b expected 1", er); end checks++;
    run_op(1'b0, 2'd3, 1'b0, WA, 24'h0, rd, er, lt);
    if (er !== 1'b1 || lt !== 1 || rd !== 24'h0) begin errors++; $display("FAIL size3_load: got err %b lat %0d rdata %h expected 1 1 000000", er, lt, rd); end checks++;
    run_op(1'b1, 2'd3, 1'b0, WA, 24'h999999, rd, er, lt);
    if (er !== 1'b1) begin errors++; $display("FAIL size3_store_err: got %b expected 1", er); end checks++;
    run_op(1'b0, 2'd0, 1'b0, WA, 24'h0, rd, er, lt);
    if (rd !== 24'h0000A1) begin errors++; $display("FAIL size3_store_untouched: got %h expected 0000a1", rd); end checks++;
  endtask

  task automatic test_align;
    logic [23:0] rd; logic er; int lt;
`ifdef DM_ALIGN_CHECK_EN
    run_op(1'b1, 2'd2, 1'b0, 24'd5, 24'h445566, rd, er, lt);
    if (er !== 1'b1 || lt !== 1) begin errors++; $display("FAIL align_word_err: got err %b lat %0d expected 1 1", er, lt); end checks++;
    run_op(1'b0, 2'd0, 1'b0, 24'd5, 24'h0, rd, er, lt);
    if (rd !== 24'h0000C3) begin errors++; $display("FAIL align_untouched: got %h expected 0000c3", rd); end checks++;
    run_op(1'b0, 2'd1, 1'b0, 24'd9, 24'h0, rd, er, lt);
    if (er !== 1'b1) begin errors++; $display("FAIL align_half_err: got %b expected 1", er); end checks++;
`else
    logic [23:0] exp_b [3];
    logic [23:0] adr [3];
    exp_b[0] = 24'h000011; exp_b[1] = 24'h000022; exp_b[2] = 24'h000033;
    adr[0] = 24'd254; adr[1] = 24'd255; adr[2] = 24'd0;
    run_op(1'b1, 2'd2, 1'b0, 24'd254, 24'h112233, rd, er, lt);
    if (er !== 1'b0 || lt !== 4) begin errors++; $display("FAIL wrap_store: got err %b lat %0d expected 0 4", er, lt); end checks++;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, 2'd0, 1'b0, adr[k], 24'h0, rd, er, lt);
      if (rd !== exp_b[k]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h expected %h", k, rd, exp_b[k]); end checks++;
    end
    run_op(1'b0, 2'd2, 1'b0, 24'd254, 24'h0, rd, er, lt);
    if (rd !== 24'h112233) begin errors++; $display("FAIL wrap_word_load: got %h expected 112233", rd); end checks++;
`endif
  endtask

  task automatic test_back_to_back;
    int first_rsp, second_rsp, zeros_a, zeros_b;
    logic [23:0] rd_b;
    first_rsp = -1; second_rsp = -1; zeros_a = 0; zeros_b = 0; rd_b = 24'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 24'd18; req_wdata = 24'h010203;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 1) begin req_addr = 24'd30; req_wdata = 24'hFFFFFF; end
      if (!req_ready) begin
        if (c <= 4) zeros_a++;
        else zeros_b++;
      end
      if (rsp_valid) begin
        if (first_rsp < 0) begin
          first_rsp = c; req_we = 1'b0; req_addr = 24'd18; req_wdata = 24'h0;
        end else if (second_rsp < 0) begin
          second_rsp = c; rd_b = rsp_rdata; req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    if (first_rsp !== 3) begin errors++; $display("FAIL b2b_first_rsp: got %0d expected 3", first_rsp); end checks++;
    if (second_rsp !== 8) begin errors++; $display("FAIL b2b_second_rsp: got %0d expected 8", second_rsp); end checks++;
    if (zeros_a !== 4) begin errors++; $display("FAIL b2b_busy_a: got %0d expected 4", zeros_a); end checks++;
    if (zeros_b !== 4) begin errors++; $display("FAIL b2b_busy_b: got %0d expected 4", zeros_b); end checks++;
    if (rd_b !== 24'h010203) begin errors++; $display("FAIL b2b_load_data: got %h expected 010203", rd_b); end checks++;
  endtask

  task automatic test_reset_mid;
    logic [23:0] rd; logic er; int lt; logic saw_rsp;
    logic [23:0] exp_b [3];
    exp_b[0] = 24'h0000DD; exp_b[1] = 24'h000002; exp_b[2] = 24'h000002;
    run_op(1'b1, 2'd2, 1'b0, 24'd12, 24'h020202, rd, er, lt);
    run_op(1'b0, 2'd0, 1'b0, 24'd12, 24'h0, rd, er, lt);
    if (rd !== 24'h000002) begin errors++; $display("FAIL rmid_prefill: got %h expected 000002", rd); end checks++;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 24'd12; req_wdata = 24'hDDEEFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    if (req_ready !== 1'b1 || rsp_rdata !== 24'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs: got ready %b rdata %h err %b expected 1 000000 0", req_ready, rsp_rdata, rsp_err);
    end checks++;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    if (saw_rsp !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp: got %b expected 0", saw_rsp); end checks++;
    for (int k = 0; k < 3; k++) begin
      run_op(1'b0, 2'd0, 1'b0, 24'd12 + 24'(k), 24'h0, rd, er, lt);
      if (rd !== exp_b[k]) begin errors++; $display("FAIL rmid_byte[%0d]: got %h expected %h", k, rd, exp_b[k]); end checks++;
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sign();
    test_range();
    test_align();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
